// File: rtl/snake_key_decoder_pkg.sv
// snake_key_decoder_pkg
//  Shared definitions for the snake game keyboard front end: set-2 scan codes used by the
//  game, PS/2 prefix bytes, command strobe bit positions, the frame receiver state type and
//  the scan-code to command decode table.
package snake_key_decoder_pkg;

   // Game scan codes (set 2)
   localparam logic [7:0] KEY_S        = 8'h1B;
   localparam logic [7:0] KEY_P        = 8'h4D;
   localparam logic [7:0] KEY_R        = 8'h2D;
   localparam logic [7:0] KEY_ESC      = 8'h76;
   localparam logic [7:0] KEY_RT       = 8'h74;
   localparam logic [7:0] KEY_LF       = 8'h6B;
   localparam logic [7:0] KEY_UP       = 8'h75;
   localparam logic [7:0] KEY_DN       = 8'h72;
   localparam logic [7:0] KEY_KP_PLUS  = 8'h79;
   localparam logic [7:0] KEY_KP_MINUS = 8'h7B;

   // PS/2 prefixes
   localparam logic [7:0] PS2_BRK = 8'hF0;
   localparam logic [7:0] PS2_EXT = 8'hE0;

   // Command strobe vector layout (MSB first: start .. speedDown)
   localparam int NUM_CMDS      = 10;
   localparam int CMD_START     = 9;
   localparam int CMD_PAUSE     = 8;
   localparam int CMD_RESUME    = 7;
   localparam int CMD_STOP      = 6;
   localparam int CMD_U         = 5;
   localparam int CMD_D         = 4;
   localparam int CMD_L         = 3;
   localparam int CMD_R         = 2;
   localparam int CMD_SPEEDUP   = 1;
   localparam int CMD_SPEEDDOWN = 0;

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rxState_t;

   // Un-prefixed table. Arrows are included because the keypad arrows (NumLock off) send the
   // same codes without E0 and should steer too.
   function automatic logic [NUM_CMDS-1:0] decodeBare(input logic [7:0] code);
      logic [NUM_CMDS-1:0] cmd;
      cmd = '0;
      case (code)
         KEY_S:        cmd[CMD_START]     = 1'b1;
         KEY_P:        cmd[CMD_PAUSE]     = 1'b1;
         KEY_R:        cmd[CMD_RESUME]    = 1'b1;
         KEY_ESC:      cmd[CMD_STOP]      = 1'b1;
         KEY_UP:       cmd[CMD_U]         = 1'b1;
         KEY_DN:       cmd[CMD_D]         = 1'b1;
         KEY_LF:       cmd[CMD_L]         = 1'b1;
         KEY_RT:       cmd[CMD_R]         = 1'b1;
         KEY_KP_PLUS:  cmd[CMD_SPEEDUP]   = 1'b1;
         KEY_KP_MINUS: cmd[CMD_SPEEDDOWN] = 1'b1;
         default:      cmd = '0;
      endcase
      return cmd;
   endfunction

   // With the E0 prefix only the arrow cluster is meaningful; any other extended code is
   // decoded as though it had arrived bare.
   function automatic logic [NUM_CMDS-1:0] decodeKey(input logic [7:0] code, input logic ext);
      logic [NUM_CMDS-1:0] cmd;
      cmd = '0;
      if (ext) begin
         case (code)
            KEY_UP:  cmd[CMD_U] = 1'b1;
            KEY_DN:  cmd[CMD_D] = 1'b1;
            KEY_LF:  cmd[CMD_L] = 1'b1;
            KEY_RT:  cmd[CMD_R] = 1'b1;
            default: cmd = decodeBare(code);
         endcase
      end else begin
         cmd = decodeBare(code);
      end
      return cmd;
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
//  Receives one 11-bit PS/2 frame (start, 8 data LSB first, odd parity, stop) from the raw
//  keyboard pins. Both pins pass through a 2-FF synchronizer; everything is sampled on the
//  falling edge of the synchronized clock. A stalled frame is abandoned after TIMEOUT_CYCLES
//  without a falling edge.
// Ports
//  clk100Mhz  in   system clock
//  rst        in   asynchronous active-high reset
//  ps2Clk     in   raw PS/2 clock pin
//  ps2Data    in   raw PS/2 data pin
//  rxByte     out  last good byte
//  byteValid  out  one-cycle pulse when rxByte is updated
//  frameErr   out  one-cycle pulse on bad parity or stop bit
module ps2_rx_frame
   import snake_key_decoder_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       clk100Mhz,
   input  logic       rst,
   input  logic       ps2Clk,
   input  logic       ps2Data,
   output logic [7:0] rxByte,
   output logic       byteValid,
   output logic       frameErr
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [2:0] clkSync;    // [1] is the synchronized clock, [2] its previous value
   logic [1:0] dataSync;
   logic       fallEdge;
   logic       dataBit;
   logic       timeout;

   rxState_t   state, stateNext;
   logic [7:0] shiftReg;
   logic [2:0] bitCnt;
   logic       parityBit;
   logic [TW-1:0] idleCnt;

   assign dataBit  = dataSync[1];
   assign fallEdge = clkSync[2] & ~clkSync[1];
   assign timeout  = (state != RX_IDLE) && !fallEdge && (idleCnt == TW'(TIMEOUT_CYCLES - 1));

   // Synchronizers reset to the idle-high bus level so reset release cannot fake an edge.
   always_ff @(posedge clk100Mhz or posedge rst) begin
      if (rst) begin
         clkSync  <= 3'b111;
         dataSync <= 2'b11;
      end else begin
         clkSync  <= {clkSync[1:0], ps2Clk};
         dataSync <= {dataSync[0], ps2Data};
      end
   end

   always_ff @(posedge clk100Mhz or posedge rst) begin
      if (rst) state <= RX_IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      if (timeout) begin
         stateNext = RX_IDLE;
      end else if (fallEdge) begin
         case (state)
            RX_IDLE:   if (!dataBit) stateNext = RX_DATA;
            RX_DATA:   if (bitCnt == 3'd7) stateNext = RX_PARITY;
            RX_PARITY: stateNext = RX_STOP;
            RX_STOP:   stateNext = RX_IDLE;
            default:   stateNext = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk100Mhz or posedge rst) begin
      if (rst) begin
         shiftReg  <= '0;
         bitCnt    <= '0;
         parityBit <= 1'b0;
         idleCnt   <= '0;
         rxByte    <= '0;
         byteValid <= 1'b0;
         frameErr  <= 1'b0;
      end else begin
         byteValid <= 1'b0;
         frameErr  <= 1'b0;

         if (state == RX_IDLE || fallEdge) idleCnt <= '0;
         else                              idleCnt <= idleCnt + TW'(1);

         if (fallEdge) begin
            case (state)
               RX_IDLE:   bitCnt <= '0;
               RX_DATA: begin
                  shiftReg <= {dataBit, shiftReg[7:1]};
                  bitCnt   <= bitCnt + 3'd1;
               end
               RX_PARITY: parityBit <= dataBit;
               RX_STOP: begin
                  // Odd parity: data plus parity bit must hold an odd number of ones.
                  if (dataBit && (^{shiftReg, parityBit})) begin
                     rxByte    <= shiftReg;
                     byteValid <= 1'b1;
                  end else begin
                     frameErr  <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/snake_key_decoder.sv
// snake_key_decoder
//  PS/2 keyboard front end for the snake game. Tracks the E0/F0 prefixes, decodes make codes
//  into one-hot command strobes and stretches each strobe for HOLD_CYCLES so the 40 Hz game
//  logic always sees it.
// Ports
//  clk100Mhz, rst             system clock, asynchronous active-high reset
//  ps2Clk, ps2Data            raw keyboard pins
//  start pause resume stop    command strobes (S, P, R, ESC)
//  u d l r                    direction strobes (arrows, E0 optional)
//  speedUp speedDown          keypad + / keypad -
//  scanCode                   last accepted make code
//  codeValid                  one-cycle pulse when scanCode updates
//  frameErr                   one-cycle pulse on a bad frame
module snake_key_decoder
   import snake_key_decoder_pkg::*;
#(
   parameter int HOLD_CYCLES    = 2500000,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       clk100Mhz,
   input  logic       rst,
   input  logic       ps2Clk,
   input  logic       ps2Data,
   output logic       start,
   output logic       pause,
   output logic       resume,
   output logic       stop,
   output logic       u,
   output logic       d,
   output logic       l,
   output logic       r,
   output logic       speedUp,
   output logic       speedDown,
   output logic [7:0] scanCode,
   output logic       codeValid,
   output logic       frameErr
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);

   logic [7:0]          rxByte;
   logic                byteValid;
   logic                brk, ext;
   logic                makeVld;
   logic [7:0]          makeCode;
   logic [NUM_CMDS-1:0] makeCmd;
   logic [NUM_CMDS-1:0] cmd;
   logic [HW-1:0]       holdCnt;

   ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) uRx (
      .clk100Mhz (clk100Mhz),
      .rst       (rst),
      .ps2Clk    (ps2Clk),
      .ps2Data   (ps2Data),
      .rxByte    (rxByte),
      .byteValid (byteValid),
      .frameErr  (frameErr)
   );

   // Prefix tracking and decode stage.
   always_ff @(posedge clk100Mhz or posedge rst) begin
      if (rst) begin
         brk      <= 1'b0;
         ext      <= 1'b0;
         makeVld  <= 1'b0;
         makeCode <= '0;
         makeCmd  <= '0;
      end else begin
         makeVld <= 1'b0;
         if (byteValid) begin
            if (rxByte == PS2_EXT) begin
               ext <= 1'b1;
            end else if (rxByte == PS2_BRK) begin
               brk <= 1'b1;
            end else if (brk) begin
               // Key release: swallow it, active strobes run out on their own.
               brk <= 1'b0;
               ext <= 1'b0;
            end else begin
               ext      <= 1'b0;
               makeVld  <= 1'b1;
               makeCode <= rxByte;
               makeCmd  <= decodeKey(rxByte, ext);
            end
         end
      end
   end

   // Output stage: scan code, valid pulse and stretched one-hot strobes. A new recognised key
   // overwrites cmd outright, so the previous strobe drops the same cycle the new one rises.
   always_ff @(posedge clk100Mhz or posedge rst) begin
      if (rst) begin
         scanCode  <= '0;
         codeValid <= 1'b0;
         cmd       <= '0;
         holdCnt   <= '0;
      end else begin
         codeValid <= makeVld;
         if (makeVld) scanCode <= makeCode;
         if (makeVld && (makeCmd != '0)) begin
            cmd     <= makeCmd;
            holdCnt <= HW'(HOLD_CYCLES);
         end else if (holdCnt != '0) begin
            holdCnt <= holdCnt - HW'(1);
            // Loaded with HOLD_CYCLES on the rising cycle, so clearing on the last count
            // keeps the strobe high for exactly HOLD_CYCLES cycles.
            if (holdCnt == HW'(1)) cmd <= '0;
         end
      end
   end

   assign start     = cmd[CMD_START];
   assign pause     = cmd[CMD_PAUSE];
   assign resume    = cmd[CMD_RESUME];
   assign stop      = cmd[CMD_STOP];
   assign u         = cmd[CMD_U];
   assign d         = cmd[CMD_D];
   assign l         = cmd[CMD_L];
   assign r         = cmd[CMD_R];
   assign speedUp   = cmd[CMD_SPEEDUP];
   assign speedDown = cmd[CMD_SPEEDDOWN];

endmodule

// File: tb/tb_snake_key_decoder.sv
// tb_snake_key_decoder
//  Directed bench for snake_key_decoder. The PS/2 bus is time-scaled (20 clk per bit) so that
//  a whole frame fits inside one strobe hold; HOLD is therefore longer than a frame, which is
//  what makes key replacement and typematic reload observable.
module tb_snake_key_decoder;

   localparam int HOLD    = 300;
   localparam int TIMEOUT = 200;
   localparam int HALF    = 10;   // PS/2 half period in clk cycles

   // Strobe vector bit positions (start is MSB)
   localparam int I_START = 9, I_PAUSE = 8, I_RESUME = 7, I_STOP = 6, I_U = 5, I_D = 4;
   localparam int I_L = 3, I_R = 2, I_SPUP = 1, I_SPDN = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ps2Clk = 1'b1;
   logic ps2Data = 1'b1;
   logic start, pause, resume, stop, u, d, l, r, speedUp, speedDown;
   logic [7:0] scanCode;
   logic codeValid, frameErr;
   logic [9:0] cmdVec;

   snake_key_decoder #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk100Mhz (clk), .rst (rst), .ps2Clk (ps2Clk), .ps2Data (ps2Data),
      .start (start), .pause (pause), .resume (resume), .stop (stop),
      .u (u), .d (d), .l (l), .r (r), .speedUp (speedUp), .speedDown (speedDown),
      .scanCode (scanCode), .codeValid (codeValid), .frameErr (frameErr)
   );

   always #5 clk = ~clk;

   assign cmdVec = {start, pause, resume, stop, u, d, l, r, speedUp, speedDown};

   // ---------------- monitor (owns all event counters) ----------------
   int         cvCnt = 0, feCnt = 0, cvWide = 0, ohErr = 0;
   logic [7:0] lastScan = '0;
   logic [9:0] lastCmdAtCv = '0, prevCmd = '0;
   logic       prevCv = 1'b0;
   logic [1:0] resRiseStop = 2'b00;
   int         riseCnt[10];
   int         runCur[10];
   int         lastRun[10];

   always @(negedge clk) begin
      if (codeValid) begin
         cvCnt++;
         lastScan    = scanCode;
         lastCmdAtCv = cmdVec;
         if (prevCv) cvWide++;
      end
      if (frameErr) feCnt++;
      if ($countones(cmdVec) > 1) ohErr++;
      for (int i = 0; i < 10; i++) begin
         if (cmdVec[i]) begin
            if (!prevCmd[i]) riseCnt[i]++;
            runCur[i]++;
         end else if (runCur[i] != 0) begin
            lastRun[i] = runCur[i];
            runCur[i]  = 0;
         end
      end
      if (cmdVec[I_RESUME] && !prevCmd[I_RESUME]) resRiseStop = {prevCmd[I_STOP], cmdVec[I_STOP]};
      prevCmd = cmdVec;
      prevCv  = codeValid;
   end

   // ---------------- checking ----------------
   int passCnt = 0, totalCnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // ---------------- stimulus ----------------
   function automatic logic [10:0] mkFrame(input logic [7:0] code, input logic parOk);
      logic par;
      par = parOk ? ~^code : ^code;
      return {1'b1, par, code, 1'b0};
   endfunction

   // Data changes while the clock is high (after its rising edge), sampled on the fall.
   task automatic sendRaw(input logic [10:0] frm, input int nBits);
      for (int i = 0; i < nBits; i++) begin
         @(negedge clk) ps2Data = frm[i];
         repeat (HALF - 1) @(negedge clk);
         ps2Clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2Clk = 1'b1;
      end
      ps2Data = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic sendByte(input logic [7:0] code);
      sendRaw(mkFrame(code, 1'b1), 11);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1; ps2Clk = 1'b1; ps2Data = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] code;
      logic [9:0] expCmd;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int cv0, fe0, rs0, rs1;

      vecs[0]  = '{8'h1B, 10'b1 << I_START};
      vecs[1]  = '{8'h4D, 10'b1 << I_PAUSE};
      vecs[2]  = '{8'h2D, 10'b1 << I_RESUME};
      vecs[3]  = '{8'h76, 10'b1 << I_STOP};
      vecs[4]  = '{8'h75, 10'b1 << I_U};
      vecs[5]  = '{8'h72, 10'b1 << I_D};
      vecs[6]  = '{8'h6B, 10'b1 << I_L};
      vecs[7]  = '{8'h74, 10'b1 << I_R};
      vecs[8]  = '{8'h79, 10'b1 << I_SPUP};
      vecs[9]  = '{8'h7B, 10'b1 << I_SPDN};
      vecs[10] = '{8'h12, 10'b0};   // left shift: not a game key
      vecs[11] = '{8'h29, 10'b0};   // space: not a game key

      // Reset state (rst held high from time 0)
      repeat (3) @(negedge clk);
      chk("reset_cmd", 32'(cmdVec), 32'h0);
      chk("reset_scan", 32'(scanCode), 32'h0);
      chk("reset_cv_fe", 32'({codeValid, frameErr}), 32'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Decode table, one key per reset
      for (int i = 0; i < 12; i++) begin
         doReset();
         cv0 = cvCnt;
         sendByte(vecs[i].code);
         repeat (10) @(negedge clk);
         chk($sformatf("vec%0d_cv", i), 32'(cvCnt - cv0), 32'd1);
         chk($sformatf("vec%0d_scan", i), 32'(lastScan), 32'(vecs[i].code));
         chk($sformatf("vec%0d_cmd", i), 32'(lastCmdAtCv), 32'(vecs[i].expCmd));
      end

      // 1. S: start high exactly HOLD cycles, codeValid one cycle wide
      doReset();
      cv0 = cvCnt; rs0 = riseCnt[I_START];
      sendByte(8'h1B);
      repeat (HOLD + 20) @(negedge clk);
      chk("t1_cv", 32'(cvCnt - cv0), 32'd1);
      chk("t1_scan", 32'(lastScan), 32'h1B);
      chk("t1_start_rises", 32'(riseCnt[I_START] - rs0), 32'd1);
      chk("t1_start_len", 32'(lastRun[I_START]), 32'(HOLD));
      chk("t1_start_now", 32'(start), 32'd0);

      // 2. E0 75 -> u; E0 F0 75 -> no codeValid, u runs its full count
      doReset();
      cv0 = cvCnt; rs0 = riseCnt[I_U];
      sendByte(8'hE0);
      sendByte(8'h75);
      repeat (5) @(negedge clk);
      chk("t2_cv", 32'(cvCnt - cv0), 32'd1);
      chk("t2_u_at_cv", 32'(lastCmdAtCv), 32'(10'b1 << I_U));
      cv0 = cvCnt;
      sendByte(8'hE0);
      sendByte(8'hF0);
      sendByte(8'h75);
      repeat (20) @(negedge clk);
      chk("t2_release_cv", 32'(cvCnt - cv0), 32'd0);
      chk("t2_u_rises", 32'(riseCnt[I_U] - rs0), 32'd1);
      chk("t2_u_len", 32'(lastRun[I_U]), 32'(HOLD));

      // Typematic: same key twice keeps one continuous strobe longer than HOLD
      doReset();
      rs0 = riseCnt[I_L];
      sendByte(8'h6B);
      sendByte(8'h6B);
      repeat (HOLD + 20) @(negedge clk);
      chk("rep_l_rises", 32'(riseCnt[I_L] - rs0), 32'd1);
      chk("rep_l_longer", 32'(lastRun[I_L] > HOLD), 32'd1);

      // 3. Parity error on 74
      doReset();
      cv0 = cvCnt; fe0 = feCnt; rs0 = riseCnt[I_R];
      sendRaw(mkFrame(8'h74, 1'b0), 11);
      repeat (20) @(negedge clk);
      chk("t3_fe", 32'(feCnt - fe0), 32'd1);
      chk("t3_cv", 32'(cvCnt - cv0), 32'd0);
      chk("t3_r", 32'(riseCnt[I_R] - rs0), 32'd0);

      // Bad stop bit
      fe0 = feCnt; cv0 = cvCnt;
      sendRaw(mkFrame(8'h1B, 1'b1) & 11'h3FF, 11);
      repeat (20) @(negedge clk);
      chk("stopbit_fe", 32'(feCnt - fe0), 32'd1);
      chk("stopbit_cv", 32'(cvCnt - cv0), 32'd0);

      // 4. ESC then R: stop hands over to resume in the same cycle
      doReset();
      rs0 = riseCnt[I_RESUME];
      sendByte(8'h76);
      repeat (20) @(negedge clk);
      sendByte(8'h2D);
      repeat (HOLD + 20) @(negedge clk);
      chk("t4_handover", 32'(resRiseStop), 32'b10);
      chk("t4_resume_rises", 32'(riseCnt[I_RESUME] - rs0), 32'd1);
      chk("t4_resume_len", 32'(lastRun[I_RESUME]), 32'(HOLD));
      chk("t4_stop_short", 32'(lastRun[I_STOP] < HOLD), 32'd1);

      // 5. Partial frame, silence past the timeout, then a full 4D
      doReset();
      cv0 = cvCnt; fe0 = feCnt; rs0 = riseCnt[I_PAUSE];
      sendRaw(mkFrame(8'h4D, 1'b1), 5);
      repeat (TIMEOUT + 50) @(negedge clk);
      sendByte(8'h4D);
      repeat (20) @(negedge clk);
      chk("t5_cv", 32'(cvCnt - cv0), 32'd1);
      chk("t5_scan", 32'(lastScan), 32'h4D);
      chk("t5_pause", 32'(riseCnt[I_PAUSE] - rs0), 32'd1);
      chk("t5_fe", 32'(feCnt - fe0), 32'd0);
      chk("t5_cmd", 32'(cmdVec), 32'(10'b1 << I_PAUSE));

      // 6. Asynchronous reset while u is held and a frame is in flight
      doReset();
      sendByte(8'h75);
      sendRaw(mkFrame(8'h1B, 1'b1), 6);
      chk("t6_u_before", 32'(u), 32'd1);
      #3 rst = 1'b1;
      #1;
      chk("t6_async_cmd", 32'(cmdVec), 32'h0);
      chk("t6_async_scan", 32'(scanCode), 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      cv0 = cvCnt; rs1 = riseCnt[I_D]; fe0 = feCnt;
      sendByte(8'h72);
      repeat (10) @(negedge clk);
      chk("t6_cv", 32'(cvCnt - cv0), 32'd1);
      chk("t6_scan", 32'(lastScan), 32'h72);
      chk("t6_d", 32'(riseCnt[I_D] - rs1), 32'd1);
      chk("t6_fe", 32'(feCnt - fe0), 32'd0);

      // Run-wide invariants
      chk("cv_one_cycle", 32'(cvWide), 32'd0);
      chk("strobes_one_hot", 32'(ohErr), 32'd0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
